// File: rtl/soc_system_sram_req_out.sv
// HPS-to-fabric request flag port: Avalon-MM writable flags that auto-clear on
// a rising acknowledge edge, with a sticky W1C acknowledge log driving irq.
module soc_system_sram_req_out #(
  parameter int unsigned       W         = 6,
  parameter logic [W-1:0]      RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    address,
  input  logic          chipselect,
  input  logic          write_n,
  input  logic [31:0]   writedata,
  output logic [31:0]   readdata,
  input  logic [W-1:0]  ack_port,
  output logic [W-1:0]  out_port,
  output logic          irq
);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_SET    = 2'd1;
  localparam logic [1:0] ADDR_CLEAR  = 2'd2;
  localparam logic [1:0] ADDR_ACKSTS = 2'd3;

  logic [W-1:0] out_q,     out_d;
  logic [W-1:0] ack_sts_q, ack_sts_d;
  logic [W-1:0] ack_q,     ack_d;
  logic [31:0]  rdata_q,   rdata_d;

  logic         wr;
  logic [W-1:0] wd;
  logic [W-1:0] rise;
  logic [W-1:0] touch;
  logic [W-1:0] wr_result;
  logic [W-1:0] w1c_mask;

  assign wr   = chipselect & ~write_n;
  assign wd   = writedata[W-1:0];
  assign rise = ack_port & ~ack_q;

  // touch marks bits owned by a CPU write this cycle; those beat the auto-clear.
  always_comb begin
    touch     = '0;
    wr_result = out_q;
    w1c_mask  = '0;
    if (wr) begin
      unique case (address)
        ADDR_DATA: begin
          touch     = '1;
          wr_result = wd;
        end
        ADDR_SET: begin
          touch     = wd;
          wr_result = out_q | wd;
        end
        ADDR_CLEAR: begin
          touch     = wd;
          wr_result = out_q & ~wd;
        end
        ADDR_ACKSTS: begin
          w1c_mask  = wd;
        end
        default: begin
          touch     = '0;
        end
      endcase
    end
  end

  always_comb begin
    out_d     = (touch & wr_result) | (~touch & out_q & ~rise);
    ack_sts_d = rise | (ack_sts_q & ~w1c_mask);
    ack_d     = ack_port;
    rdata_d   = '0;
    if (address == ADDR_ACKSTS) begin
      rdata_d[W-1:0] = ack_sts_q;
    end else begin
      rdata_d[W-1:0] = out_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q     <= RESET_VAL;
      ack_sts_q <= '0;
      ack_q     <= '0;
      rdata_q   <= '0;
    end else begin
      out_q     <= out_d;
      ack_sts_q <= ack_sts_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
    end
  end

  assign out_port = out_q;
  assign readdata = rdata_q;
  assign irq      = |ack_sts_q;

endmodule

// File: tb/tb_soc_system_sram_req_out.sv
// Directed self-checking bench for soc_system_sram_req_out (W=6, RESET_VAL=0).
module tb_soc_system_sram_req_out;

   logic        clk;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [5:0]  ack_port;
   logic [5:0]  out_port;
   logic        irq;

   int vectors;
   int miscompares;

   soc_system_sram_req_out #(
      .W         (6),
      .RESET_VAL (6'h00)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .ack_port   (ack_port),
      .out_port   (out_port),
      .irq        (irq)
   );

   // Free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts the vector and reports any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Single-cycle Avalon write, driven and released on falling edges
   task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
      @(negedge clk);
      address    = addr;
      writedata  = data;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   // Present a read address for one edge and compare the registered readdata
   task automatic readCheck(input string tag, input logic [1:0] addr, input logic [31:0] expected);
      @(negedge clk);
      address    = addr;
      chipselect = 1'b0;
      write_n    = 1'b1;
      @(negedge clk);
      checkOutput(tag, readdata, expected);
   endtask

   // Directed sequence T1..T6
   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      address     = 2'd0;
      chipselect  = 1'b0;
      write_n     = 1'b1;
      writedata   = 32'h0;
      ack_port    = 6'h00;

      repeat (2) @(negedge clk);
      checkOutput("rst_out_port", {26'h0, out_port}, 32'h0);
      checkOutput("rst_readdata", readdata, 32'h0);
      checkOutput("rst_irq", {31'h0, irq}, 32'h0);
      reset = 1'b0;

      // T1: reset lands in the middle of a DATA write
      @(negedge clk);
      address    = 2'd0;
      writedata  = 32'h3F;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #2;
      checkOutput("t1_pre_reset_out", {26'h0, out_port}, 32'h3F);
      reset = 1'b1;
      #1;
      checkOutput("t1_async_out", {26'h0, out_port}, 32'h0);
      checkOutput("t1_async_readdata", readdata, 32'h0);
      checkOutput("t1_async_irq", {31'h0, irq}, 32'h0);
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      reset      = 1'b0;
      @(negedge clk);
      checkOutput("t1_release_out", {26'h0, out_port}, 32'h0);

      // T2: data/set/clear
      applyStimulus(2'd0, 32'h05);
      checkOutput("t2_data", {26'h0, out_port}, 32'h05);
      applyStimulus(2'd1, 32'h0A);
      checkOutput("t2_set", {26'h0, out_port}, 32'h0F);
      applyStimulus(2'd2, 32'h03);
      checkOutput("t2_clear", {26'h0, out_port}, 32'h0C);
      readCheck("t2_read0", 2'd0, 32'h0C);

      // T3: one-cycle acknowledge pulse on bit 2
      @(negedge clk);
      ack_port = 6'h04;
      @(negedge clk);
      ack_port = 6'h00;
      checkOutput("t3_autoclear", {26'h0, out_port}, 32'h08);
      checkOutput("t3_irq_set", {31'h0, irq}, 32'h1);
      readCheck("t3_read_acksts", 2'd3, 32'h04);
      applyStimulus(2'd3, 32'h04);
      checkOutput("t3_irq_w1c", {31'h0, irq}, 32'h0);

      // T4a: SET bit 2 collides with a rise on bit 2
      @(negedge clk);
      address    = 2'd1;
      writedata  = 32'h04;
      chipselect = 1'b1;
      write_n    = 1'b0;
      ack_port   = 6'h04;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      ack_port   = 6'h00;
      checkOutput("t4_set_beats_ack", {26'h0, out_port}, 32'h0C);
      readCheck("t4_acksts_bit2", 2'd3, 32'h04);
      applyStimulus(2'd3, 32'h04);
      checkOutput("t4_irq_cleared", {31'h0, irq}, 32'h0);

      // T4b: W1C bit 0 collides with a rise on bit 0 (out_port[0] already 0)
      @(negedge clk);
      address    = 2'd3;
      writedata  = 32'h01;
      chipselect = 1'b1;
      write_n    = 1'b0;
      ack_port   = 6'h01;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      ack_port   = 6'h00;
      checkOutput("t4_out_unchanged", {26'h0, out_port}, 32'h0C);
      readCheck("t4_edge_beats_w1c", 2'd3, 32'h01);
      applyStimulus(2'd3, 32'h01);
      checkOutput("t4_irq_cleared2", {31'h0, irq}, 32'h0);

      // T5: level acknowledge on bit 1 held for 10 cycles, re-SET at cycle 5
      applyStimulus(2'd1, 32'h02);
      checkOutput("t5_armed", {26'h0, out_port}, 32'h0E);
      ack_port = 6'h02;
      for (int i = 1; i <= 10; i++) begin
         chipselect = 1'b0;
         write_n    = 1'b1;
         if (i == 2) begin
            address    = 2'd3;
            writedata  = 32'h02;
            chipselect = 1'b1;
            write_n    = 1'b0;
         end else if (i == 5) begin
            address    = 2'd1;
            writedata  = 32'h02;
            chipselect = 1'b1;
            write_n    = 1'b0;
         end
         @(negedge clk);
         checkOutput($sformatf("t5_out_c%0d", i), {26'h0, out_port}, (i < 5) ? 32'h0C : 32'h0E);
         checkOutput($sformatf("t5_irq_c%0d", i), {31'h0, irq}, (i == 1) ? 32'h1 : 32'h0);
      end
      chipselect = 1'b0;
      write_n    = 1'b1;
      ack_port   = 6'h00;
      readCheck("t5_single_event", 2'd3, 32'h00);

      // T6: upper writedata bits ignored, upper readdata bits zero
      applyStimulus(2'd0, 32'hFFFF_FFC0);
      checkOutput("t6_data_upper", {26'h0, out_port}, 32'h00);
      applyStimulus(2'd1, 32'hFFFF_FFFF);
      checkOutput("t6_set_all", {26'h0, out_port}, 32'h3F);
      readCheck("t6_read0", 2'd0, 32'h3F);
      readCheck("t6_read1", 2'd1, 32'h3F);
      readCheck("t6_read2", 2'd2, 32'h3F);
      @(negedge clk);
      ack_port = 6'h3F;
      @(negedge clk);
      ack_port = 6'h00;
      checkOutput("t6_all_acked", {26'h0, out_port}, 32'h00);
      readCheck("t6_read3", 2'd3, 32'h3F);

      $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
